// File: rtl/alu_pipe_measure.sv
// alu_pipe_measure: elastic ALU pipeline with registered result flags and a saturating retired-beat counter
module alu_pipe_measure #(
    parameter int N      = 5,
    parameter int STAGES = 2,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [3:0]    sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  result,
    output logic          z,
    output logic          o,
    output logic          ca,
    output logic          neg,
    input  logic          clr_count,
    output logic [CW-1:0] op_count
);
    localparam int DW = N + 4;

    logic [STAGES-1:0] v_q, v_d, rdy;
    logic [2*N+3:0]    s0_q, s0_d;
    logic [DW-1:0]     sr_q [1:STAGES-1];
    logic [DW-1:0]     sr_d [1:STAGES-1];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      oa, ob, alu_r;
    logic [3:0]        op;
    logic [N:0]        sum, dif;
    logic              alu_ca, alu_o, retire, r;

    assign {oa, ob, op} = s0_q;

    always_comb begin
        sum    = {1'b0, oa} + {1'b0, ob};
        dif    = {1'b0, oa} - {1'b0, ob};
        alu_r  = op == 4'd0 ? sum[N-1:0] :
                 op == 4'd1 ? dif[N-1:0] :
                 op == 4'd2 ? oa & ob :
                 op == 4'd3 ? oa | ob :
                 op == 4'd4 ? oa ^ ob :
                 op == 4'd5 ? {oa[N-2:0], 1'b0} :
                 op == 4'd6 ? {1'b0, oa[N-1:1]} :
                 op == 4'd7 ? oa : '0;
        alu_ca = op == 4'd0 ? sum[N] :
                 op == 4'd1 ? dif[N] :
                 op == 4'd5 ? oa[N-1] :
                 op == 4'd6 ? oa[0] : 1'b0;
        alu_o  = op == 4'd0 ? (oa[N-1] == ob[N-1]) && (alu_r[N-1] != oa[N-1]) :
                 op == 4'd1 ? (oa[N-1] != ob[N-1]) && (alu_r[N-1] != oa[N-1]) : 1'b0;
    end

    // A stage can load when it, or every full stage ahead of it, drains this cycle
    always_comb begin
        r = out_ready || !v_q[STAGES-1];
        rdy = '0;
        rdy[STAGES-1] = r;
        for (int i = STAGES - 2; i >= 0; i--) begin
            r = r || !v_q[i];
            rdy[i] = r;
        end
    end

    assign in_ready  = rst && rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign retire    = v_q[STAGES-1] && out_ready;
    assign {result, z, o, ca, neg} = sr_q[STAGES-1];
    assign op_count  = cnt_q;

    always_comb begin
        v_d    = v_q;
        v_d[0] = rdy[0] ? in_valid : v_q[0];
        s0_d   = (rdy[0] && in_valid) ? {a, b, sel} : s0_q;
        sr_d   = sr_q;
        v_d[1] = rdy[1] ? v_q[0] : v_q[1];
        sr_d[1] = (rdy[1] && v_q[0]) ? {alu_r, alu_r == '0, alu_o, alu_ca, alu_r[N-1]} : sr_q[1];
        for (int i = 2; i < STAGES; i++) begin
            v_d[i]  = rdy[i] ? v_q[i-1] : v_q[i];
            sr_d[i] = (rdy[i] && v_q[i-1]) ? sr_q[i-1] : sr_q[i];
        end
        cnt_d = clr_count ? '0 : (retire && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            s0_q  <= '0;
            for (int i = 1; i < STAGES; i++) sr_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            s0_q  <= s0_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe_measure.sv
// tb_alu_pipe_measure: directed and random checks of alu_pipe_measure against a position-tracking beat model
module tb_alu_pipe_measure;
    localparam int N = 5;
    localparam int S = 2;

    logic clk = 0, rst = 0, in_valid = 0, out_ready = 0, clr_count = 0;
    logic [N-1:0] a = '0, b = '0;
    logic [3:0] sel = '0;
    logic in_ready, out_valid, z, o, ca, neg;
    logic [N-1:0] result;
    logic [15:0] op_count;
    logic in_ready2, out_valid2, z2, o2, ca2, neg2;
    logic [N-1:0] result2;
    logic [1:0] op_count2;

    alu_pipe_measure #(.N(N), .STAGES(S), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .z(z), .o(o), .ca(ca), .neg(neg),
        .clr_count(clr_count), .op_count(op_count));

    alu_pipe_measure #(.N(N), .STAGES(S), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .sel(sel),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .z(z2), .o(o2), .ca(ca2), .neg(neg2),
        .clr_count(clr_count), .op_count(op_count2));

    always #5 clk = ~clk;

    typedef struct { logic [8:0] d; int pos; } item_t;
    item_t q[$];
    int cnt, cnt2, total, bad;
    logic acc;

    // Result and flags {result, z, o, ca, neg} from plain integer arithmetic on 5-bit operands
    function automatic logic [8:0] model(input int x, input int y, input int s);
        int r, c, ov, sx, sy, t;
        logic [4:0] rr;
        r = 0; c = 0; ov = 0;
        sx = x >= 16 ? x - 32 : x;
        sy = y >= 16 ? y - 32 : y;
        case (s)
            0: begin r = x + y; c = int'(r >= 32); t = sx + sy; ov = int'(t > 15 || t < -16); end
            1: begin r = x - y; c = int'(x < y); t = sx - sy; ov = int'(t > 15 || t < -16); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin r = x * 2; c = int'(x >= 16); end
            6: begin r = x / 2; c = x % 2; end
            7: r = x;
            default: r = 0;
        endcase
        rr = 5'(r & 31);
        return {rr, rr == 5'd0, ov[0], c[0], rr[4]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic iv, input int xa, input int xb, input int xs,
                       input logic ordy, input logic clr, output logic accepted);
        logic ov, ret, ir;
        int lim;
        in_valid = iv; a = N'(xa); b = N'(xb); sel = 4'(xs); out_ready = ordy; clr_count = clr;
        #1;
        ov = q.size() > 0 && q[0].pos == S - 1;
        chk("out_valid", out_valid, ov);
        if (ov) begin
            chk("result", result, q[0].d[8:4]);
            chk("flags", {z, o, ca, neg}, q[0].d[3:0]);
        end
        chk("op_count", op_count, cnt);
        chk("op_count_cw2", op_count2, cnt2);
        ret = ov && ordy;
        if (ret) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) begin
            lim = i == 0 ? S - 1 : q[i-1].pos - 1;
            q[i].pos = q[i].pos + 1 < lim ? q[i].pos + 1 : lim;
        end
        ir = q.size() == 0 || q[q.size()-1].pos != 0;
        chk("in_ready", in_ready, ir);
        accepted = iv && ir;
        if (accepted) q.push_back('{model(xa, xb, xs), 0});
        if (clr) begin cnt = 0; cnt2 = 0; end
        else if (ret) begin
            if (cnt < 65535) cnt++;
            if (cnt2 < 3) cnt2++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dir(input int xa, input int xb, input int xs, input int er, input logic [3:0] ef);
        logic t;
        cyc(1, xa, xb, xs, 1, 0, t);
        cyc(0, 0, 0, 0, 1, 0, t);
        chk("dir_valid", out_valid, 1);
        chk("dir_result", result, er);
        chk("dir_flags", {z, o, ca, neg}, ef);
        cyc(0, 0, 0, 0, 1, 0, t);
    endtask

    initial begin
        int xa, xb, xs, pend;
        in_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_result", result, 0);
        in_valid = 0;
        @(negedge clk);
        rst = 1;

        dir(12, 7, 0, 19, 4'b0101);
        dir(3, 5, 1, 30, 4'b0011);
        dir(21, 21, 4, 0, 4'b1000);
        dir(17, 0, 5, 2, 4'b0010);
        dir(17, 3, 9, 0, 4'b1000);

        cyc(1, 1, 2, 0, 0, 0, acc);
        cyc(1, 9, 4, 1, 0, 0, acc);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 6, 3, 3, 0, 0, acc);
            chk("stall_in_ready", acc, 0);
        end
        cyc(1, 6, 3, 3, 1, 0, acc);
        chk("stall_resume_acc", acc, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, acc);

        cyc(1, 10, 11, 0, 0, 0, acc);
        cyc(1, 13, 2, 2, 0, 0, acc);
        rst = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        q.delete(); cnt = 0; cnt2 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, acc);

        for (int i = 0; i < 6; i++) cyc(1, i, i + 1, i % 8, 1, 0, acc);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, acc);
        chk("sat_cw2", op_count2, 3);
        cyc(1, 1, 1, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 1, 1, acc);
        cyc(0, 0, 0, 0, 1, 0, acc);
        chk("clr_priority", op_count, 0);

        pend = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                xa = $urandom_range(0, 31); xb = $urandom_range(0, 31); xs = $urandom_range(0, 15);
            end
            cyc(1'($urandom_range(0, 3) != 0), xa, xb, xs, 1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 99) < 3), acc);
            pend = (in_valid && !acc) ? 1 : 0;
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, acc);
        chk("drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe_measure.md
ALU_PIPE_MEASURE -- requirements
Module: alu_pipe_measure

Interface
REQ-001 Parameter N, default 5: operand and result width in bits (N >= 2).
REQ-002 Parameter STAGES, default 2: register stages from input capture to result output (2..4).
REQ-003 Parameter CW, default 16: width of the operation counter.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: operand beat offered.
REQ-007 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 Port a, input, N: operand A.
REQ-009 Port b, input, N: operand B.
REQ-010 Port sel, input, 4: operation select.
REQ-011 Port out_valid, output, 1: result beat available.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port result, output, N: operation result.
REQ-014 Port z, o, ca, neg, outputs, 1 each: flags registered alongside result.
REQ-015 Port clr_count, input, 1: synchronous clear of op_count.
REQ-016 Port op_count, output, CW: number of result beats accepted downstream.

Function
REQ-017 A beat is accepted when in_valid && in_ready, and retired when out_valid && out_ready.
REQ-018 Elastic pipeline: each stage holds a valid bit; a stage loads when empty or when its content moves forward in the same cycle.
REQ-019 in_ready = stage-0 empty OR stage-0 advancing; combinational only from internal valids and out_ready.
REQ-020 Stage 0 captures {a, b, sel}; the operation is computed combinationally from stage 0 into stage 1; stages 2..STAGES-1 are delay registers.
REQ-021 Unstalled latency: result on output exactly STAGES cycles after acceptance; sustained throughput one beat per cycle.
REQ-022 Operations: 0 add, 1 sub (a-b), 2 and, 3 or, 4 xor, 5 shl by 1, 6 logical shr by 1, 7 pass a; codes 8..15 give result 0.
REQ-023 z = (result == 0), for every sel.
REQ-024 neg = result[N-1], for every sel.
REQ-025 ca: add = carry out of bit N-1; sub = borrow (a < b unsigned); shl = a[N-1]; shr = a[0]; otherwise 0.
REQ-026 o: add/sub = two's-complement signed overflow; otherwise 0.
REQ-027 While out_valid && !out_ready, result, flags and out_valid hold stable; no beat is dropped, duplicated or reordered.
REQ-028 Full pipeline with out_ready=1 and in_valid=1: accept and retire in the same cycle.
REQ-029 op_count increments by 1 per retired beat; saturates at 2^CW-1 (no wrap).
REQ-030 clr_count has priority over increment: a retire in the same cycle leaves op_count at 0.

Reset
REQ-031 rst low asynchronously clears all valid bits, stage data, result, flags and op_count to 0.
REQ-032 During reset in_ready = 0 and out_valid = 0; in-flight beats are discarded, not completed.
REQ-033 First acceptance is possible in the first rising edge after rst is released.

Verification
REQ-034 N=5, STAGES=2, sel=0, a=12, b=7, out_ready=1 -> after 2 cycles result=19, z=0, ca=0, o=1, neg=1.
REQ-035 sel=1, a=3, b=5 -> result=30, ca=1, neg=1, o=0, z=0; sel=4, a=b=21 -> result=0, z=1.
REQ-036 Three back-to-back beats, out_ready low 5 cycles -> in_ready drops after 2 accepted, outputs held stable, then 3 results in order with no gap once out_ready=1.
REQ-037 rst pulsed low mid-stream with 2 beats in flight -> out_valid=0, op_count=0 immediately; no stale result after release.
REQ-038 CW=2, 5 retired beats -> op_count stays 3; clr_count with a simultaneous retire -> op_count=0.
REQ-039 sel=5, a=5'b10001 -> result=5'b00010, ca=1; sel=9 -> result=0, z=1, ca=o=neg=0.
